knn_sort_scheduler: RTL

Sequencing controller that sits in front of and behind the distance-sort network in the KNN datapath. It collects a serial stream of (distance, class-type) pairs into a batch of N = 2^L slots and pads unused slots. It launches one sort on the parallel sorter, waits for the sorter's completion strobe (with timeout), and streams the K nearest results out serially under valid/ready backpressure.

---
 rtl/knn_sort_scheduler.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/knn_sort_scheduler.sv
// knn_sort_scheduler
// Sequencing controller around the parallel distance sorter of the KNN datapath.
// Collects a serial stream of (distance, type) items into a batch of N = 2^L
// slots. Unused slots are padded with all-ones distance and type 0. It launches
// one sort, waits for the sorter's result strobe (bounded by TIMEOUT), then
// streams the K nearest results out under valid/ready backpressure.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             input item handshake
//   in_dist/in_type/in_last       input item payload, in_last closes the batch
//   srt_in_valid                  one-cycle launch strobe to the sorter
//   srt_ascending                 sort direction (always ascending)
//   srt_in/srt_in_type            packed padded batch, slot i at [W*(i+1)-1:W*i]
//   srt_out/srt_out_type          sorted batch from the sorter, slot 0 smallest
//   srt_out_valid                 sorter result strobe
//   out_valid/out_ready           result handshake
//   out_dist/out_type/out_last    result payload, out_last marks the final result
//   ovf                           sticky: batch closed at N items without in_last
//   err                           sticky: sorter timeout
module knn_sort_scheduler #(
  parameter int L       = 3,
  parameter int W       = 16,
  parameter int TYPE_W  = 3,
  parameter int K       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_dist,
  input  logic [TYPE_W-1:0]     in_type,
  input  logic                  in_last,
  output logic                  srt_in_valid,
  output logic                  srt_ascending,
  output logic [W*(1<<L)-1:0]   srt_in,
  output logic [TYPE_W*(1<<L)-1:0] srt_in_type,
  input  logic [W*(1<<L)-1:0]   srt_out,
  input  logic [TYPE_W*(1<<L)-1:0] srt_out_type,
  input  logic                  srt_out_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_dist,
  output logic [TYPE_W-1:0]     out_type,
  output logic                  out_last,
  output logic                  ovf,
  output logic                  err
);

  localparam int N     = 1 << L;
  localparam int CNT_W = $clog2(N + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                in_ready_q, srt_in_valid_q;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_dist_q, out_dist_d;
  logic [TYPE_W-1:0]   out_type_q, out_type_d;
  logic                out_last_q, out_last_d;

  logic [W-1:0]        fill_dist_q [N];
  logic [TYPE_W-1:0]   fill_type_q [N];
  logic [W-1:0]        res_dist_q  [N];
  logic [TYPE_W-1:0]   res_type_q  [N];
  logic [W*N-1:0]      srt_in_q;
  logic [TYPE_W*N-1:0] srt_in_type_q;

  logic                accept;
  logic                close_batch;
  logic                load_res;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    idx_nxt;
  logic [CNT_W-1:0]    e_cnt;
  logic [W*N-1:0]      pad_dist;
  logic [TYPE_W*N-1:0] pad_type;

  assign in_ready      = in_ready_q;
  assign srt_in_valid  = srt_in_valid_q;
  assign srt_ascending = 1'b1;
  assign srt_in        = srt_in_q;
  assign srt_in_type   = srt_in_type_q;
  assign out_valid     = out_valid_q;
  assign out_dist      = out_dist_q;
  assign out_type      = out_type_q;
  assign out_last      = out_last_q;
  assign ovf           = ovf_q;
  assign err           = err_q;

  // Item acceptance and batch-close detection
  always_comb begin
    accept      = (state_q == S_FILL) && in_valid;
    cnt_inc     = cnt_q + CNT_W'(1);
    idx_nxt     = idx_q + CNT_W'(1);
    close_batch = accept && (in_last || (cnt_q == CNT_W'(N - 1)));
    if (cnt_q < CNT_W'(K)) begin
      e_cnt = cnt_q;
    end else begin
      e_cnt = CNT_W'(K);
    end
  end

  // Padded batch image including the item accepted this cycle
  always_comb begin
    pad_dist = {(W*N){1'b0}};
    pad_type = {(TYPE_W*N){1'b0}};
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) < cnt_inc) begin
        if (CNT_W'(i) == cnt_q) begin
          pad_dist[W*i +: W]           = in_dist;
          pad_type[TYPE_W*i +: TYPE_W] = in_type;
        end else begin
          pad_dist[W*i +: W]           = fill_dist_q[i];
          pad_type[TYPE_W*i +: TYPE_W] = fill_type_q[i];
        end
      end else begin
        pad_dist[W*i +: W]           = {W{1'b1}};
        pad_type[TYPE_W*i +: TYPE_W] = {TYPE_W{1'b0}};
      end
    end
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_dist_d  = out_dist_q;
    out_type_d  = out_type_q;
    out_last_d  = out_last_q;
    load_res    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (close_batch) begin
            state_d = S_LAUNCH;
          end else begin
            state_d = S_FILL;
          end
          // Batch closed by capacity rather than by in_last
          if (!in_last && (cnt_q == CNT_W'(N - 1))) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        tmo_d   = {TMO_W{1'b0}};
      end
      S_WAIT: begin
        if (srt_out_valid) begin
          state_d     = S_DRAIN;
          load_res    = 1'b1;
          idx_d       = {CNT_W{1'b0}};
          out_valid_d = 1'b1;
          out_dist_d  = srt_out[W-1:0];
          out_type_d  = srt_out_type[TYPE_W-1:0];
          out_last_d  = (e_cnt == CNT_W'(1));
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // Sorter never answered: abandon the batch silently
          state_d = S_FILL;
          err_d   = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == (e_cnt - CNT_W'(1))) begin
            state_d     = S_FILL;
            cnt_d       = {CNT_W{1'b0}};
            idx_d       = {CNT_W{1'b0}};
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_nxt;
            out_dist_d = res_dist_q[idx_nxt[L-1:0]];
            out_type_d = res_type_q[idx_nxt[L-1:0]];
            out_last_d = (idx_nxt == (e_cnt - CNT_W'(1)));
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Control state and registered handshake/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_FILL;
      cnt_q          <= {CNT_W{1'b0}};
      idx_q          <= {CNT_W{1'b0}};
      tmo_q          <= {TMO_W{1'b0}};
      ovf_q          <= 1'b0;
      err_q          <= 1'b0;
      in_ready_q     <= 1'b1;
      srt_in_valid_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_dist_q     <= {W{1'b0}};
      out_type_q     <= {TYPE_W{1'b0}};
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      tmo_q          <= tmo_d;
      ovf_q          <= ovf_d;
      err_q          <= err_d;
      in_ready_q     <= (state_d == S_FILL);
      srt_in_valid_q <= (state_d == S_LAUNCH);
      out_valid_q    <= out_valid_d;
      out_dist_q     <= out_dist_d;
      out_type_q     <= out_type_d;
      out_last_q     <= out_last_d;
    end
  end

  // Fill buffer: accepted items land in slot cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        fill_dist_q[i] <= {W{1'b0}};
        fill_type_q[i] <= {TYPE_W{1'b0}};
      end
    end else if (accept) begin
      fill_dist_q[cnt_q[L-1:0]] <= in_dist;
      fill_type_q[cnt_q[L-1:0]] <= in_type;
    end
  end

  // Sorter launch image (held between launches) and captured result buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srt_in_q      <= {(W*N){1'b0}};
      srt_in_type_q <= {(TYPE_W*N){1'b0}};
      for (int i = 0; i < N; i++) begin
        res_dist_q[i] <= {W{1'b0}};
        res_type_q[i] <= {TYPE_W{1'b0}};
      end
    end else begin
      if (close_batch) begin
        srt_in_q      <= pad_dist;
        srt_in_type_q <= pad_type;
      end
      if (load_res) begin
        for (int i = 0; i < N; i++) begin
          res_dist_q[i] <= srt_out[W*i +: W];
          res_type_q[i] <= srt_out_type[TYPE_W*i +: TYPE_W];
        end
      end
    end
  end

endmodule
